// File: rtl/fifo_stream_packer.sv
// rtl/fifo_stream_packer.sv - packs RATIO narrow FIFO words into one wide valid/ready word
// Drains a fifo_v3-style read port; flush_i emits a zero-padded partial word with lane strobes.
module fifo_stream_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH * RATIO
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  pop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic [RATIO-1:0]      strb_o,
  output logic                  busy_o
);

  localparam int CW  = $clog2(RATIO);
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [OUT_WIDTH-1:0] acc_q, acc_d, acc_fill;
  logic [CW-1:0]        lane_cnt_q, lane_cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [RATIO-1:0]     strb_q, strb_d, strb_flush;
  logic                 valid_q, valid_d;

  logic                 out_free, last_lane, pop, complete, pend_eff, flush_fire;
  logic [CW:0]          fill_cnt;

  assign out_free  = ~valid_q | ready_i;
  assign last_lane = (lane_cnt_q == LAST_LANE);
  // Only the word-completing pop waits for the output register; lower lanes keep filling.
  assign pop       = ~rst_i & ~empty_i & ~(last_lane & ~out_free);
  assign complete  = pop & last_lane;
  assign pend_eff  = flush_pend_q | (flush_i & ((lane_cnt_q != '0) | pop));
  assign flush_fire = pend_eff & out_free & ~complete;
  assign fill_cnt  = {1'b0, lane_cnt_q} + {{CW{1'b0}}, pop};

  always_comb begin
    acc_fill   = acc_q;
    strb_flush = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (pop && (lane_cnt_q == CW'(k))) begin
        acc_fill[k*DATA_WIDTH +: DATA_WIDTH] = data_i;
      end
      strb_flush[k] = (CW1'(k) < fill_cnt);
    end
  end

  always_comb begin
    acc_d        = acc_fill;
    lane_cnt_d   = pop ? lane_cnt_q + CW'(1) : lane_cnt_q;
    flush_pend_d = pend_eff;
    data_d       = data_q;
    strb_d       = strb_q;
    valid_d      = valid_q & ~ready_i;
    if (complete) begin
      data_d       = acc_fill;
      strb_d       = '1;
      valid_d      = 1'b1;
      acc_d        = '0;
      lane_cnt_d   = '0;
      flush_pend_d = 1'b0;
    end else if (flush_fire) begin
      // Accumulator lanes above the fill point are already zero, so padding is free.
      data_d       = acc_fill;
      strb_d       = strb_flush;
      valid_d      = 1'b1;
      acc_d        = '0;
      lane_cnt_d   = '0;
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q        <= '0;
      lane_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
      strb_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      lane_cnt_q   <= lane_cnt_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      valid_q      <= valid_d;
    end
  end

  assign pop_o   = pop;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign strb_o  = strb_q;
  assign busy_o  = (lane_cnt_q != '0);

endmodule

// File: tb/tb_fifo_stream_packer.sv
// tb/tb_fifo_stream_packer.sv - self-checking bench for fifo_stream_packer
module tb_fifo_stream_packer;
  localparam int DW = 8;
  localparam int R  = 4;
  localparam int OW = DW * R;

  logic          clk = 1'b0;
  logic          rst, flush, empty, ready, pop, valid, busy;
  logic [DW-1:0] din;
  logic [OW-1:0] dout;
  logic [R-1:0]  strb;

  always #5 clk = ~clk;

  fifo_stream_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .empty_i(empty), .data_i(din),
    .pop_o(pop), .valid_o(valid), .ready_i(ready), .data_o(dout), .strb_o(strb),
    .busy_o(busy)
  );

  typedef struct {
    logic [OW-1:0] d;
    logic [R-1:0]  s;
  } exp_t;

  typedef struct {
    int            n;
    logic [OW-1:0] words;
    bit            fl;
    logic [OW-1:0] d;
    logic [R-1:0]  s;
  } vec_t;

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  vec_t          vecs[6];
  int            checks = 0;
  int            errors = 0;
  int            pops   = 0;
  int            base;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void drive_fifo();
    empty = (fifo_q.size() == 0);
    din   = empty ? 8'hEE : fifo_q[0];
  endfunction

  function automatic void push_word(logic [DW-1:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endfunction

  function automatic void expect_word(logic [OW-1:0] d, logic [R-1:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
  endfunction

  // One clock: monitor at negedge, then advance the FIFO model after the edge.
  task automatic step();
    exp_t e;
    logic p;
    @(negedge clk);
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", dout);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", dout, e.d);
        check("sb_strb", strb, e.s);
      end
    end
    if (pop && (empty || rst)) begin
      checks++;
      errors++;
      $display("FAIL illegal_pop actual=1 required=0");
    end
    p = pop;
    @(posedge clk);
    #1;
    if (p) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    drive_fifo();
  endtask

  task automatic drain();
    int n = 0;
    ready = 1'b1;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || valid) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=<200", n);
    end
  endtask

  initial begin
    vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF};
    vecs[1] = '{4, 32'hDDCCBBAA, 1'b0, 32'hDDCCBBAA, 4'hF};
    vecs[2] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'b0011};
    vecs[3] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'b0001};
    vecs[4] = '{3, 32'h00C3B2A1, 1'b1, 32'h00C3B2A1, 4'b0111};
    vecs[5] = '{4, 32'h04030201, 1'b1, 32'h04030201, 4'hF};

    rst   = 1'b1;
    flush = 1'b0;
    ready = 1'b1;
    push_word(8'h99);
    #1;
    check("rst_valid", valid, 0);
    check("rst_data", dout, 0);
    check("rst_strb", strb, 0);
    check("rst_busy", busy, 0);
    check("rst_pop", pop, 0);
    fifo_q.delete();
    drive_fifo();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic pack and one-cycle latency
    expect_word(32'h44332211, 4'hF);
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    base = pops;
    step(); step(); step();
    check("basic_valid_early", valid, 0);
    step();
    check("basic_pops", pops - base, 4);
    check("basic_valid", valid, 1);
    check("basic_data", dout, 32'h44332211);
    check("basic_strb", strb, 4'hF);
    step();
    check("basic_valid_drop", valid, 0);

    // Backpressure with eight queued words
    ready = 1'b0;
    expect_word(32'h44332211, 4'hF);
    expect_word(32'h88776655, 4'hF);
    for (int k = 1; k <= 8; k++) push_word(8'((k << 4) | k));
    base = pops;
    for (int k = 0; k < 10; k++) step();
    check("bp_pops_blocked", pops - base, 7);
    check("bp_hold_data", dout, 32'h44332211);
    check("bp_hold_valid", valid, 1);
    check("bp_busy", busy, 1);
    ready = 1'b1;
    step();
    check("bp_pops_final", pops - base, 8);
    check("bp_second_valid", valid, 1);
    check("bp_second_data", dout, 32'h88776655);
    step();
    check("bp_valid_drop", valid, 0);

    // Flush while stalled
    ready = 1'b0;
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h00E3E2E1, 4'b0111);
    push_word(8'h01); push_word(8'h02); push_word(8'h03); push_word(8'h04); push_word(8'hE1);
    base = pops;
    for (int k = 0; k < 5; k++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    push_word(8'hE2); push_word(8'hE3);
    for (int k = 0; k < 4; k++) step();
    check("fs_pops", pops - base, 7);
    check("fs_hold_data", dout, 32'h04030201);
    ready = 1'b1;
    step();
    check("fs_flush_valid", valid, 1);
    check("fs_flush_strb", strb, 4'b0111);
    check("fs_flush_data", dout, 32'h00E3E2E1);
    check("fs_busy", busy, 0);
    drain();

    // Flush coinciding with the completing pop
    expect_word(32'h0D0C0B0A, 4'hF);
    push_word(8'h0A); push_word(8'h0B); push_word(8'h0C);
    step(); step(); step();
    push_word(8'h0D);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fc_strb", strb, 4'hF);
    check("fc_data", dout, 32'h0D0C0B0A);
    drain();
    for (int k = 0; k < 3; k++) step();

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      int n = 0;
      expect_word(vecs[i].d, vecs[i].s);
      for (int k = 0; k < vecs[i].n; k++) push_word(vecs[i].words[k*DW +: DW]);
      while (fifo_q.size() != 0 && n < 50) begin
        step();
        n++;
      end
      if (vecs[i].fl) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      drain();
      for (int k = 0; k < 2; k++) step();
    end

    // Idle flush: no output, no state change
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("idle_valid", valid, 0);
    check("idle_busy", busy, 0);

    // Async reset mid-word with a stalled output word
    ready = 1'b0;
    for (int k = 0; k < 7; k++) push_word(8'(8'h10 + k));
    for (int k = 0; k < 6; k++) step();
    check("ar_pre_valid", valid, 1);
    check("ar_pre_busy", busy, 1);
    check("ar_pre_pop", pop, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", valid, 0);
    check("ar_data", dout, 0);
    check("ar_strb", strb, 0);
    check("ar_busy", busy, 0);
    check("ar_pop", pop, 0);
    fifo_q.delete();
    drive_fifo();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready = 1'b1;
    expect_word(32'h24232221, 4'hF);
    push_word(8'h21); push_word(8'h22); push_word(8'h23); push_word(8'h24);
    drain();
    for (int k = 0; k < 3; k++) step();
    check("sb_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
